// File: rtl/timer_pkg.sv
// Shared constants for the microsecond timer scheduler: timebase divider,
// requester channel indices and the duration width.
package timer_pkg;

    localparam int CLK_DIV_1US = 36;
    localparam int DUR_W       = 16;

    localparam int CH_ALIEN = 0;
    localparam int CH_SHOT  = 1;
    localparam int CH_UFO   = 2;
    localparam int CH_SOUND = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant over the eligible
// requests, searching from the channel after the last one granted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = $clog2(N);

    // start_q is the first index searched; 0 after reset so channel 0 leads.
    logic [PTR_W-1:0] start_q, start_d;
    logic             found;
    int               idx;

    always_comb begin
        gnt     = '0;
        start_d = start_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                start_d  = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

endmodule

// File: rtl/us_timer_sched.sv
// One shared 1 us timebase serving NUM_CH one-shot microsecond delays.
// Build option TIMER_CANCEL_EN adds a per-channel cancel input.
module us_timer_sched #(
    parameter int CLK_DIV = timer_pkg::CLK_DIV_1US,
    parameter int NUM_CH  = 4,
    parameter int DUR_W   = timer_pkg::DUR_W
) (
    input  logic                    clk_36MHz,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*DUR_W-1:0] dur,
`ifdef TIMER_CANCEL_EN
    input  logic [NUM_CH-1:0]       cancel,
`endif
    output logic [NUM_CH-1:0]       gnt,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    tick_1us
);

    import timer_pkg::*;

    localparam int PRE_W = $clog2(CLK_DIV);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] cancel_v;

`ifdef TIMER_CANCEL_EN
    assign cancel_v = cancel;
`else
    assign cancel_v = '0;
`endif

    always_comb begin
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (en) begin
            if (pre_q == PRE_W'(CLK_DIV - 1)) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            gnt_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            gnt_q  <= gnt_d;
        end
    end

    // A channel granted last cycle is masked so a held req cannot double-load.
    assign elig = req & ~busy & ~gnt_q;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk   (clk_36MHz),
        .rst_n (reset),
        .req   (elig),
        .gnt   (gnt_d)
    );

    assign gnt      = gnt_q;
    assign tick_1us = tick_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DUR_W-1:0] cnt_q, cnt_d, dur_i;
        logic             busy_q, busy_d, done_q, done_d;

        assign dur_i = dur[i*DUR_W +: DUR_W];

        // Priority: load, then cancel, then countdown on the registered tick.
        always_comb begin
            cnt_d  = cnt_q;
            busy_d = busy_q;
            done_d = 1'b0;
            if (gnt_d[i]) begin
                cnt_d  = dur_i;
                busy_d = (dur_i != '0);
                done_d = (dur_i == '0);
            end else if (cancel_v[i]) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else if (tick_q && busy_q) begin
                if (cnt_q == DUR_W'(1)) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk_36MHz or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                busy_q <= busy_d;
                done_q <= done_d;
            end
        end

        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_us_timer_sched.sv
// Directed bench for us_timer_sched: expected grant/done events are queued
// by cycle number and a negedge monitor pops and compares them.
module tb_us_timer_sched;

    import timer_pkg::*;

    localparam int NCH = 4;
    localparam int EW  = 23;

    logic             clk_36MHz = 1'b0;
    logic             reset     = 1'b0;
    logic             en        = 1'b0;
    logic [NCH-1:0]   req       = '0;
    logic [NCH*DUR_W-1:0] dur   = '0;
`ifdef TIMER_CANCEL_EN
    logic [NCH-1:0]   cancel    = '0;
`endif
    logic [NCH-1:0]   gnt, busy, done;
    logic             tick_1us;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int base    = 0;
    int en_cnt  = 0;
    logic last_en = 1'b0;

    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk_36MHz = ~clk_36MHz;

    always @(posedge clk_36MHz) cyc <= cyc + 1;

    // Reference timebase: a tick follows every 36th enabled edge since reset.
    always @(posedge clk_36MHz or negedge reset) begin
        if (!reset) begin
            en_cnt  <= 0;
            last_en <= 1'b0;
        end else begin
            last_en <= en;
            if (en) en_cnt <= en_cnt + 1;
        end
    end

    us_timer_sched dut (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .dur       (dur),
`ifdef TIMER_CANCEL_EN
        .cancel    (cancel),
`endif
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .tick_1us  (tick_1us)
    );

    // Requesters drop req in the cycle their grant is visible.
    initial begin
        forever begin
            @(negedge clk_36MHz);
            req = req & ~gnt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    function automatic logic [EW-1:0] ev(input int c, input bit kind, input int ch);
        logic [19:0] cc;
        logic [1:0]  hh;
        cc = c[19:0];
        hh = ch[1:0];
        return {cc, kind, hh};
    endfunction

    task automatic push_exp(input int r, input bit kind, input int ch);
        logic [EW-1:0] key;
        int pos;
        bit placed;
        key    = ev(base + r, kind, ch);
        pos    = exp_q.size();
        placed = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (!placed && exp_q[k] > key) begin
                pos    = k;
                placed = 1'b1;
            end
        end
        exp_q.insert(pos, key);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, expv);
        end
    endtask

    task automatic report_missing(input logic [EW-1:0] e);
        vec_cnt++;
        err_cnt++;
        $display("FAIL missing_%s_ch%0d: got nothing at cyc %0d, required event",
                 e[2] ? "done" : "gnt", e[1:0], e[22:3]);
    endtask

    task automatic check_ev(input bit kind, input int ch);
        logic [EW-1:0] act, e;
        act = ev(cyc, kind, ch);
        vec_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_%s_ch%0d: got event at cyc %0d, required none",
                     kind ? "done" : "gnt", ch, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                err_cnt++;
                $display("FAIL %s_ch%0d: got cyc=%0d kind=%0d ch=%0d, required cyc=%0d kind=%0d ch=%0d",
                         kind ? "done" : "gnt", ch, cyc, kind, ch, e[22:3], e[2], e[1:0]);
            end
        end
    endtask

    always @(negedge clk_36MHz) begin
        while (exp_q.size() > 0 && exp_q[0][22:3] < cyc[19:0]) begin
            report_missing(exp_q.pop_front());
        end
        for (int i = 0; i < NCH; i++) if (gnt[i])  check_ev(1'b0, i);
        for (int i = 0; i < NCH; i++) if (done[i]) check_ev(1'b1, i);
        if (reset) begin
            check("tick_1us", {31'd0, tick_1us},
                  {31'd0, last_en && en_cnt != 0 && (en_cnt % 36) == 0});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_36MHz);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        req   = '0;
        dur   = '0;
`ifdef TIMER_CANCEL_EN
        cancel = '0;
`endif
        repeat (2) @(negedge clk_36MHz);
        #1;
        reset = 1'b1;
        en    = 1'b1;
        base  = cyc;
    endtask

    task automatic wait_to(input int r);
        while (cyc < base + r) @(negedge clk_36MHz);
    endtask

    task automatic issue(input int ch, input int d);
        dur[ch*DUR_W +: DUR_W] = DUR_W'(d);
        req[ch] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Contention from reset: channels granted 0,1,2,3 on consecutive edges.
        do_reset();
        check("reset_gnt",  {28'd0, gnt},  32'd0);
        check("reset_busy", {28'd0, busy}, 32'd0);
        check("reset_done", {28'd0, done}, 32'd0);
        for (int i = 0; i < NCH; i++) begin
            issue(i, 2);
            push_exp(1 + i, 1'b0, i);
            push_exp(73, 1'b1, i);
        end
        wait_to(5);
        check("contend_busy", {28'd0, busy}, 32'hF);
        wait_to(73);
        check("contend_idle", {28'd0, busy}, 32'h0);
        wait_to(80);

        // Single delays, zero duration, and load coinciding with a tick.
        do_reset();
        issue(CH_ALIEN, 3);
        push_exp(1, 1'b0, CH_ALIEN);
        push_exp(109, 1'b1, CH_ALIEN);
        wait_to(1);
        check("single_busy", {31'd0, busy[CH_ALIEN]}, 32'd1);
        wait_to(10);
        issue(CH_UFO, 0);
        push_exp(11, 1'b0, CH_UFO);
        push_exp(11, 1'b1, CH_UFO);
        wait_to(11);
        check("zero_busy", {31'd0, busy[CH_UFO]}, 32'd0);
        wait_to(35);
        issue(CH_SOUND, 1);
        push_exp(36, 1'b0, CH_SOUND);
        push_exp(37, 1'b1, CH_SOUND);
        wait_to(36);
        issue(CH_UFO, 1);
        push_exp(37, 1'b0, CH_UFO);
        push_exp(73, 1'b1, CH_UFO);
        wait_to(80);
        issue(CH_SHOT, 1);
        push_exp(81, 1'b0, CH_SHOT);
        push_exp(109, 1'b1, CH_SHOT);
        wait_to(109);
        check("single_idle", {28'd0, busy}, 32'h0);
        wait_to(115);

        // Freeze for 100 cycles: done lands 100 cycles later than the run above.
        do_reset();
        issue(CH_ALIEN, 3);
        push_exp(1, 1'b0, CH_ALIEN);
        push_exp(209, 1'b1, CH_ALIEN);
        wait_to(50);
        en = 1'b0;
        wait_to(60);
        issue(CH_SHOT, 5);
        push_exp(61, 1'b0, CH_SHOT);
        push_exp(317, 1'b1, CH_SHOT);
        wait_to(150);
        check("freeze_busy", {28'd0, busy}, 32'h3);
        en = 1'b1;
        wait_to(320);

        // Reset mid-count kills the pending delay.
        do_reset();
        issue(CH_ALIEN, 5);
        push_exp(1, 1'b0, CH_ALIEN);
        wait_to(20);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_gnt",  {28'd0, gnt},  32'd0);
        check("midrst_busy", {28'd0, busy}, 32'd0);
        check("midrst_done", {28'd0, done}, 32'd0);
        check("midrst_tick", {31'd0, tick_1us}, 32'd0);
        @(negedge clk_36MHz);
        #1;
        reset = 1'b1;
        base  = cyc;
        wait_to(250);
        check("midrst_idle", {28'd0, busy}, 32'h0);

`ifdef TIMER_CANCEL_EN
        // Cancel after four ticks, then a fresh request is served normally.
        do_reset();
        issue(CH_SHOT, 10);
        push_exp(1, 1'b0, CH_SHOT);
        wait_to(150);
        cancel[CH_SHOT] = 1'b1;
        wait_to(151);
        cancel = '0;
        check("cancel_busy", {31'd0, busy[CH_SHOT]}, 32'd0);
        wait_to(160);
        issue(CH_SHOT, 1);
        push_exp(161, 1'b0, CH_SHOT);
        push_exp(181, 1'b1, CH_SHOT);
        wait_to(200);
        check("cancel_idle", {28'd0, busy}, 32'h0);
`endif

        repeat (5) @(negedge clk_36MHz);
        while (exp_q.size() > 0) report_missing(exp_q.pop_front());
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
